// File: rtl/regfile_plus_pkg.sv
// Shared constants and the register next-state rule for the regfile_plus bank.
// The same next_value() function feeds both the storage update and the
// write-first read bypass, so the two can never disagree on priority.
package regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Widest register the helper can serve; callers zero-extend into it and
  // truncate the result back to their own WIDTH, which also gives the
  // modulo-2^WIDTH wrap of the increment for free.
  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] word_t;

  // Value a register holds after the next edge: a write beats an increment.
  function automatic word_t next_value(
    input word_t cur,
    input logic  we_hit,
    input word_t wdata,
    input logic  inc_hit
  );
    word_t res;
    if (we_hit) begin
      res = wdata;
    end else if (inc_hit) begin
      res = cur + word_t'(1'b1);
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_plus_if.sv
// Bus bundle for regfile_plus: write port, counter increment, two read
// ports and the debug outputs. The master drives requests, the slave
// (the register bank) drives read data, counter value and monitor bus.
interface regfile_plus_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [WIDTH-1:0]       wdata;
  logic                   inc_en;
  logic                   re1;
  logic [ADDR_W-1:0]      raddr1;
  logic                   re2;
  logic [ADDR_W-1:0]      raddr2;
  logic [WIDTH-1:0]       rd1_data;
  logic                   rd1_valid;
  logic [WIDTH-1:0]       rd2_data;
  logic                   rd2_valid;
  logic [WIDTH-1:0]       cnt_value;
  logic [DEPTH*WIDTH-1:0] monitor_bus;

  modport master (
    output we, waddr, wdata, inc_en, re1, raddr1, re2, raddr2,
    input  rd1_data, rd1_valid, rd2_data, rd2_valid, cnt_value, monitor_bus
  );

  modport slave (
    input  we, waddr, wdata, inc_en, re1, raddr1, re2, raddr2,
    output rd1_data, rd1_valid, rd2_data, rd2_valid, cnt_value, monitor_bus
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_plus. It range-checks the address,
// masks register 0 when it is hard-wired to zero, and bypasses a same-edge
// write or increment so the returned data is the post-edge register value.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_REG = DEPTH - 1,
  parameter int R0_ZERO = 0,
  parameter int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              inc_en_i,
  input  logic [WIDTH-1:0]  state_i [DEPTH],
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [31:0] CNT_U   = 32'(CNT_REG);

  logic              in_range;
  logic              zero_reg;
  logic              we_hit;
  logic              inc_hit;
  logic [ADDR_W-1:0] sel;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  nxt;
  logic [WIDTH-1:0]  rd_data_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_d;
  logic              rd_valid_q;

  // Address check, bypass of the same-edge update, and output masking.
  always_comb begin
    in_range = (32'(raddr_i) < DEPTH_U);
    zero_reg = (R0_ZERO != 0) && (raddr_i == '0);
    // Out-of-range addresses select entry 0; their data is masked below.
    sel      = in_range ? raddr_i : '0;
    cur      = state_i[sel];
    // A write to the read address is only a hit when the address exists,
    // which in_range guarantees for both sides of the equality.
    we_hit   = we_i && (waddr_i == raddr_i);
    inc_hit  = inc_en_i && (32'(raddr_i) == CNT_U);
    nxt      = WIDTH'(next_value(word_t'(cur), we_hit, word_t'(wdata_i), inc_hit));
    if (re_i && in_range && !zero_reg) begin
      rd_data_d = nxt;
    end else begin
      rd_data_d = '0;
    end
    rd_valid_d = re_i;
  end

  // Output registers; an idle cycle returns zero data with valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_plus.sv
// Multi-register bank: DEPTH x WIDTH storage with one write port, an
// auto-increment counter register, two write-first registered read ports
// and a flattened monitor bus of every register for the debug panel.
module regfile_plus
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_REG = DEPTH - 1,
  parameter int R0_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_plus_if.slave bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       regs_q [DEPTH];
  logic [WIDTH-1:0]       regs_d [DEPTH];
  logic [DEPTH*WIDTH-1:0] mon_flat;

  // Next state of every register: write decode, counter increment, and
  // the hard-wired zero of register 0 when R0_ZERO is set.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if ((R0_ZERO != 0) && (i == 0)) begin
        regs_d[i] = '0;
      end else begin
        regs_d[i] = WIDTH'(next_value(
                      word_t'(regs_q[i]),
                      bus.we && (32'(bus.waddr) == 32'(i)),
                      word_t'(bus.wdata),
                      bus.inc_en && (i == CNT_REG)));
      end
    end
  end

  // Storage array, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flatten the storage for the debug monitor, register i at [i*WIDTH +: WIDTH].
  always_comb begin
    mon_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mon_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  assign bus.monitor_bus = mon_flat;
  assign bus.cnt_value   = regs_q[CNT_REG];

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .CNT_REG (CNT_REG),
    .R0_ZERO (R0_ZERO),
    .ADDR_W  (ADDR_W)
  ) u_rd1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .re_i       (bus.re1),
    .raddr_i    (bus.raddr1),
    .we_i       (bus.we),
    .waddr_i    (bus.waddr),
    .wdata_i    (bus.wdata),
    .inc_en_i   (bus.inc_en),
    .state_i    (regs_q),
    .rd_data_o  (bus.rd1_data),
    .rd_valid_o (bus.rd1_valid)
  );

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .CNT_REG (CNT_REG),
    .R0_ZERO (R0_ZERO),
    .ADDR_W  (ADDR_W)
  ) u_rd2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .re_i       (bus.re2),
    .raddr_i    (bus.raddr2),
    .we_i       (bus.we),
    .waddr_i    (bus.waddr),
    .wdata_i    (bus.wdata),
    .inc_en_i   (bus.inc_en),
    .state_i    (regs_q),
    .rd_data_o  (bus.rd2_data),
    .rd_valid_o (bus.rd2_valid)
  );

endmodule

// File: tb/tb_regfile_plus.sv
// Bench for regfile_plus: two instances (8 regs, counter r7; 6 regs with
// r0 hard-wired to zero, counter r5) share one stimulus stream and are
// compared against an array-based model, a directed vector table and
// hand-written reset / out-of-range / r0 sequences.
module tb_regfile_plus;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       we, inc_en, re1, re2;
  logic [2:0] waddr, raddr1, raddr2;
  logic [7:0] wdata;

  regfile_plus_if #(.WIDTH(8), .DEPTH(8)) if_a ();
  regfile_plus_if #(.WIDTH(8), .DEPTH(6)) if_b ();

  assign if_a.we = we;         assign if_b.we = we;
  assign if_a.waddr = waddr;   assign if_b.waddr = waddr;
  assign if_a.wdata = wdata;   assign if_b.wdata = wdata;
  assign if_a.inc_en = inc_en; assign if_b.inc_en = inc_en;
  assign if_a.re1 = re1;       assign if_b.re1 = re1;
  assign if_a.raddr1 = raddr1; assign if_b.raddr1 = raddr1;
  assign if_a.re2 = re2;       assign if_b.re2 = re2;
  assign if_a.raddr2 = raddr2; assign if_b.raddr2 = raddr2;

  regfile_plus #(.WIDTH(8), .DEPTH(8), .CNT_REG(7), .R0_ZERO(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  regfile_plus #(.WIDTH(8), .DEPTH(6), .CNT_REG(5), .R0_ZERO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  // Reference model: plain arrays updated by the register-bank rules.
  int         depth_c [2] = '{8, 6};
  int         cnt_c   [2] = '{7, 5};
  bit         r0_c    [2] = '{1'b0, 1'b1};
  logic [7:0] m [2][8];
  logic [7:0] e_rd1 [2];
  logic [7:0] e_rd2 [2];
  logic       e_v1  [2];
  logic       e_v2  [2];

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       we;     logic [2:0] waddr;  logic [7:0] wdata; logic inc_en;
    logic       re1;    logic [2:0] raddr1; logic re2;         logic [2:0] raddr2;
    logic [7:0] x_rd1;  logic x_v1;         logic [7:0] x_rd2; logic x_v2;
    logic [7:0] x_cnt;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int k, input logic [2:0] a);
    if (int'(a) >= depth_c[k] || (r0_c[k] && a == 3'd0)) return 8'h00;
    return m[k][a];
  endfunction

  function automatic logic [63:0] model_mon(input int k);
    logic [63:0] r = 64'h0;
    for (int i = 0; i < depth_c[k]; i++) r[i*8 +: 8] = m[k][i];
    return r;
  endfunction

  // Apply one edge to model k: increment first, then an overriding write.
  task automatic model_step(input int k);
    if (inc_en && !(r0_c[k] && cnt_c[k] == 0))
      m[k][cnt_c[k]] = m[k][cnt_c[k]] + 8'd1;
    if (we && int'(waddr) < depth_c[k] && !(r0_c[k] && waddr == 3'd0))
      m[k][waddr] = wdata;
    e_v1[k]  = re1;
    e_rd1[k] = re1 ? model_read(k, raddr1) : 8'h00;
    e_v2[k]  = re2;
    e_rd2[k] = re2 ? model_read(k, raddr2) : 8'h00;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m[k][i] = 8'h00;
  endtask

  task automatic check_models();
    chk("a_rd1", if_a.rd1_data, e_rd1[0]);   chk("a_v1", if_a.rd1_valid, e_v1[0]);
    chk("a_rd2", if_a.rd2_data, e_rd2[0]);   chk("a_v2", if_a.rd2_valid, e_v2[0]);
    chk("a_cnt", if_a.cnt_value, m[0][7]);   chk("a_mon", if_a.monitor_bus, model_mon(0));
    chk("b_rd1", if_b.rd1_data, e_rd1[1]);   chk("b_v1", if_b.rd1_valid, e_v1[1]);
    chk("b_rd2", if_b.rd2_data, e_rd2[1]);   chk("b_v2", if_b.rd2_valid, e_v2[1]);
    chk("b_cnt", if_b.cnt_value, m[1][5]);   chk("b_mon", if_b.monitor_bus, model_mon(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_rd1"}, if_a.rd1_data, 64'h0);  chk({tag, "_a_v1"}, if_a.rd1_valid, 64'h0);
    chk({tag, "_a_rd2"}, if_a.rd2_data, 64'h0);  chk({tag, "_a_v2"}, if_a.rd2_valid, 64'h0);
    chk({tag, "_a_cnt"}, if_a.cnt_value, 64'h0); chk({tag, "_a_mon"}, if_a.monitor_bus, 64'h0);
    chk({tag, "_b_rd1"}, if_b.rd1_data, 64'h0);  chk({tag, "_b_v1"}, if_b.rd1_valid, 64'h0);
    chk({tag, "_b_rd2"}, if_b.rd2_data, 64'h0);  chk({tag, "_b_v2"}, if_b.rd2_valid, 64'h0);
    chk({tag, "_b_cnt"}, if_b.cnt_value, 64'h0); chk({tag, "_b_mon"}, if_b.monitor_bus, 64'h0);
  endtask

  // One clock edge: predict, clock, sample 1 time unit after the edge.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_models();
  endtask

  task automatic idle();
    we = 1'b0; waddr = 3'd0; wdata = 8'h00; inc_en = 1'b0;
    re1 = 1'b0; raddr1 = 3'd0; re2 = 1'b0; raddr2 = 3'd0;
  endtask

  initial begin
    logic [63:0] snap_b;
    idle();
    model_clear();

    // Reset state.
    @(posedge clk); #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table against dut_a (8 regs, counter r7).
    tbl[0] = '{1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 3'd5, 8'hA5, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 3'd2, 8'h3C, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 8'h3C, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 3'd7, 8'hFE, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFE};
    tbl[4] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF};
    tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd7, 1'b1, 3'd7, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[6] = '{1'b1, 3'd7, 8'h10, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 8'h10, 1'b1, 8'h00, 1'b0, 8'h10};
    tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2, 8'h3C, 1'b1, 8'h3C, 1'b1, 8'h10};
    tbl[8] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 8'h11, 1'b1, 8'h00, 1'b0, 8'h11};
    tbl[9] = '{1'b1, 3'd3, 8'h5A, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 8'h5A, 1'b1, 8'h5A, 1'b1, 8'h11};
    for (int v = 0; v < 10; v++) begin
      we = tbl[v].we; waddr = tbl[v].waddr; wdata = tbl[v].wdata; inc_en = tbl[v].inc_en;
      re1 = tbl[v].re1; raddr1 = tbl[v].raddr1; re2 = tbl[v].re2; raddr2 = tbl[v].raddr2;
      cycle();
      chk($sformatf("tbl%0d_rd1", v), if_a.rd1_data, tbl[v].x_rd1);
      chk($sformatf("tbl%0d_v1", v), if_a.rd1_valid, tbl[v].x_v1);
      chk($sformatf("tbl%0d_rd2", v), if_a.rd2_data, tbl[v].x_rd2);
      chk($sformatf("tbl%0d_v2", v), if_a.rd2_valid, tbl[v].x_v2);
      chk($sformatf("tbl%0d_cnt", v), if_a.cnt_value, tbl[v].x_cnt);
    end

    // Out-of-range write/read on the 6-register instance.
    idle();
    we = 1'b1; waddr = 3'd7; wdata = 8'h77; re1 = 1'b1; raddr1 = 3'd7; re2 = 1'b1; raddr2 = 3'd6;
    snap_b = model_mon(1);
    cycle();
    chk("b_oob_rd1", if_b.rd1_data, 64'h0);
    chk("b_oob_v1", if_b.rd1_valid, 64'h1);
    chk("b_oob_rd2", if_b.rd2_data, 64'h0);
    chk("b_oob_mon", if_b.monitor_bus, snap_b);
    chk("a_r7_cnt", if_a.cnt_value, 64'h77);

    // Register 0 hard-wired to zero on the 6-register instance only.
    idle();
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; re1 = 1'b1; raddr1 = 3'd0;
    cycle();
    chk("b_r0_rd1", if_b.rd1_data, 64'h0);
    chk("b_r0_mon", if_b.monitor_bus[7:0], 64'h0);
    chk("a_r0_rd1", if_a.rd1_data, 64'hFF);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1)); waddr = 3'($urandom_range(0, 7));
      wdata = 8'($urandom); inc_en = 1'($urandom_range(0, 1));
      re1 = 1'($urandom_range(0, 1)); raddr1 = 3'($urandom_range(0, 7));
      re2 = 1'($urandom_range(0, 1)); raddr2 = 3'($urandom_range(0, 7));
      if (n % 16 == 0) raddr1 = waddr;
      cycle();
    end

    // Asynchronous reset in the middle of active traffic.
    idle();
    we = 1'b1; waddr = 3'd1; wdata = 8'h81; re1 = 1'b1; raddr1 = 3'd1; re2 = 1'b1; raddr2 = 3'd1;
    cycle();
    chk("pre_rst_rd1", if_a.rd1_data, 64'h81);
    inc_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    @(posedge clk); #1;
    chk_zero("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    idle();
    we = 1'b1; waddr = 3'd3; wdata = 8'hC3; inc_en = 1'b1;
    re1 = 1'b1; raddr1 = 3'd3; re2 = 1'b1; raddr2 = 3'd7;
    cycle();
    chk("post_rst_rd1", if_a.rd1_data, 64'hC3);
    chk("post_rst_rd2", if_a.rd2_data, 64'h01);
    chk("post_rst_cnt", if_a.cnt_value, 64'h01);

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
